// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the run/step issue controller.
// State encodings and prescaler sizing.
package run_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_STEP  = 2'b10;
    localparam logic [1:0] ST_BREAK = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_STEP = ST_STEP,
        S_BRK  = ST_BREAK
    } run_state_e;

    function automatic int pre_width(input int div_count);
        return (div_count > 1) ? $clog2(div_count) : 1;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer with a rising-edge detector.
// Edges are suppressed until the synchronizer has refilled after reset.
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise
);

    logic       s1;
    logic       s2;
    logic       prev;
    logic [1:0] fill;

    // prev only tracks s2 once the flops hold real samples, so a level
    // held high through reset release never looks like a fresh edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b1;
            fill <= 2'b00;
        end else begin
            s1   <= din;
            s2   <= s1;
            fill <= {fill[0], 1'b1};
            if (fill[1]) begin
                prev <= s2;
            end
        end
    end

    assign level = s2;
    assign rise  = fill[1] & s2 & ~prev;

endmodule

// File: rtl/run_step_controller.sv
// Instruction issue sequencer: free-run, single-step and PC breakpoint.
// Drives a one-cycle CpuEn pulse per issued instruction.
module run_step_controller
    import run_ctrl_pkg::*;
#(
    parameter int DIV_COUNT = 50000000,
    parameter int PC_W      = 32
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            RunSw,
    input  logic            StepBtn,
    input  logic            BreakEn,
    input  logic [PC_W-1:0] BreakAddr,
    input  logic [PC_W-1:0] PCValue,
    output logic            CpuEn,
    output logic [1:0]      State,
    output logic            Halted,
    output logic [15:0]     InstrCount
);

    localparam int PW = pre_width(DIV_COUNT);
    localparam logic [PW-1:0] TERM = PW'(DIV_COUNT - 1);

    logic          run_s;
    logic          run_rise;
    logic          step_s;
    logic          step_rise;
    logic          step_go;
    logic          at_break;
    logic          pulse_d;
    run_state_e    state_q;
    run_state_e    state_d;
    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;

    sync_edge_detect u_run_sync (
        .clk   (Clk),
        .rst_n (Rst),
        .din   (RunSw),
        .level (run_s),
        .rise  (run_rise)
    );

    sync_edge_detect u_step_sync (
        .clk   (Clk),
        .rst_n (Rst),
        .din   (StepBtn),
        .level (step_s),
        .rise  (step_rise)
    );

    assign step_go  = step_rise & step_s;
    assign at_break = BreakEn && (PCValue == BreakAddr);

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        pulse_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (step_go) begin
                    state_d = S_STEP;
                end else if (run_rise) begin
                    state_d = S_RUN;
                    pre_d   = '0;
                end
            end
            S_STEP: begin
                pulse_d = 1'b1;
                state_d = S_IDLE;
            end
            S_RUN: begin
                if (!run_s) begin
                    state_d = S_IDLE;
                    pre_d   = '0;
                end else if (pre_q == TERM) begin
                    pre_d = '0;
                    if (at_break) begin
                        state_d = S_BRK;
                    end else begin
                        pulse_d = 1'b1;
                    end
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
            S_BRK: begin
                if (step_go) begin
                    state_d = S_STEP;
                end else if (!run_s) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q    <= S_IDLE;
            pre_q      <= '0;
            CpuEn      <= 1'b0;
            InstrCount <= 16'h0000;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            CpuEn   <= pulse_d;
            if (CpuEn) begin
                InstrCount <= InstrCount + 16'd1;
            end
        end
    end

    assign State  = state_q;
    assign Halted = (state_q == S_BRK);

endmodule

// File: tb/tb_run_step_controller.sv
// Scoreboard bench: expected CpuEn pulses are queued by the stimulus
// and popped by a monitor whenever the DUT issues one.
module tb_run_step_controller;
    import run_ctrl_pkg::*;

    localparam int DIV = 4;

    typedef struct {
        int cyc;
        int cnt;
    } pulse_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run_sw = 1'b0;
    logic        step_btn = 1'b0;
    logic        break_en = 1'b0;
    logic [31:0] break_addr = 32'h0;
    logic [31:0] pc = 32'h0;
    logic        cpu_en;
    logic [1:0]  state;
    logic        halted;
    logic [15:0] instr_cnt;

    logic        run_sw1 = 1'b0;
    logic        step_btn1 = 1'b0;
    logic        break_en1 = 1'b0;
    logic [31:0] break_addr1 = 32'h0;
    logic [31:0] pc1 = 32'h0;
    logic        cpu_en1;
    logic [1:0]  state1;
    logic        halted1;
    logic [15:0] instr_cnt1;

    int     cyc = 0;
    int     checks = 0;
    int     errors = 0;
    int     model_cnt = 0;
    logic [31:0] pc_m = 32'h0;
    pulse_t exp_q[$];

    run_step_controller #(.DIV_COUNT(DIV), .PC_W(32)) dut (
        .Clk        (clk),
        .Rst        (rst_n),
        .RunSw      (run_sw),
        .StepBtn    (step_btn),
        .BreakEn    (break_en),
        .BreakAddr  (break_addr),
        .PCValue    (pc),
        .CpuEn      (cpu_en),
        .State      (state),
        .Halted     (halted),
        .InstrCount (instr_cnt)
    );

    run_step_controller #(.DIV_COUNT(1), .PC_W(32)) dut1 (
        .Clk        (clk),
        .Rst        (rst_n),
        .RunSw      (run_sw1),
        .StepBtn    (step_btn1),
        .BreakEn    (break_en1),
        .BreakAddr  (break_addr1),
        .PCValue    (pc1),
        .CpuEn      (cpu_en1),
        .State      (state1),
        .Halted     (halted1),
        .InstrCount (instr_cnt1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input longint act,
                         input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: the core's PC advances on each pulse, and every pulse
    // must match the head of the expectation queue.
    always @(negedge clk) begin
        pulse_t p;
        if (!rst_n) begin
            pc = 32'h0;
        end else if (cpu_en) begin
            pc = pc + 32'd4;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: CpuEn high at cycle %0d, none expected",
                         cyc);
            end else begin
                p = exp_q.pop_front();
                check("pulse_cycle", cyc, p.cyc);
                check("pulse_instr_count", instr_cnt, p.cnt);
            end
        end
    end

    task automatic expect_pulse(input int t);
        exp_q.push_back('{t, model_cnt});
        model_cnt = (model_cnt + 1) % 65536;
        pc_m = pc_m + 32'd4;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        check("missing_pulses", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Raise RunSw and allow up to np pulses; stops early on a breakpoint
    // (leaving RunSw high), otherwise drops RunSw after the np-th pulse.
    task automatic run_burst(input int np, output bit hit);
        int k;
        int enter;
        int t;
        int f;
        hit = 1'b0;
        t = 0;
        @(negedge clk);
        k = cyc + 1;
        run_sw = 1'b1;
        enter = k + 2;
        for (int n = 0; n < np; n++) begin
            t = enter + DIV * (n + 1);
            if (break_en && pc_m == break_addr) begin
                hit = 1'b1;
                break;
            end
            expect_pulse(t);
        end
        if (hit) begin
            while (cyc < t + 1) @(negedge clk);
        end else begin
            f = enter + DIV * np - 1 + $urandom_range(0, DIV - 1);
            while (cyc < f - 1) @(negedge clk);
            run_sw = 1'b0;
            repeat (DIV + 4) @(negedge clk);
        end
        drain();
    endtask

    task automatic step_press(input int hold);
        int k;
        @(negedge clk);
        k = cyc + 1;
        step_btn = 1'b1;
        expect_pulse(k + 3);
        repeat (hold) @(negedge clk);
        step_btn = 1'b0;
        repeat (6) @(negedge clk);
        drain();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit hit;
        int k;
        int enter;
        int t;
        int low;
        int r;

        repeat (2) @(negedge clk);
        check("reset_state", state, ST_IDLE);
        check("reset_cpu_en", cpu_en, 0);
        check("reset_instr_count", instr_cnt, 0);
        check("reset_halted", halted, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // free-running bursts interleaved with single steps
        for (int it = 0; it < 3; it++) begin
            run_burst($urandom_range(3, 7), hit);
            check("run_exit_state", state, ST_IDLE);
            check("run_instr_count", instr_cnt, model_cnt);
            repeat ($urandom_range(3, 8)) @(negedge clk);
            step_press($urandom_range(1, 25));
            check("step_state", state, ST_IDLE);
            check("step_instr_count", instr_cnt, model_cnt);
            repeat ($urandom_range(3, 8)) @(negedge clk);
        end

        // breakpoint r instructions ahead of the current PC
        r = $urandom_range(1, 4);
        break_en = 1'b1;
        break_addr = pc_m + 32'(4 * r);
        run_burst(10, hit);
        check("break_hit", hit, 1);
        repeat (50) @(negedge clk);
        check("break_state", state, ST_BREAK);
        check("break_halted", halted, 1);
        check("break_instr_count", instr_cnt, model_cnt);

        // one instruction past the breakpoint, then RunSw level is ignored
        step_press($urandom_range(5, 20));
        check("past_break_state", state, ST_IDLE);
        check("past_break_halted", halted, 0);
        check("past_break_count", instr_cnt, model_cnt);
        repeat (3 * DIV + 4) @(negedge clk);
        check("held_run_no_resume", state, ST_IDLE);
        run_sw = 1'b0;
        break_en = 1'b0;
        repeat (4) @(negedge clk);
        run_burst($urandom_range(2, 5), hit);
        check("resume_count", instr_cnt, model_cnt);

        // asynchronous reset during a CpuEn-high cycle
        repeat (4) @(negedge clk);
        @(negedge clk);
        k = cyc + 1;
        run_sw = 1'b1;
        enter = k + 2;
        t = enter + DIV * $urandom_range(1, 3);
        for (int i = enter + DIV; i <= t; i += DIV) expect_pulse(i);
        while (cyc < t) @(negedge clk);
        #1;
        rst_n = 1'b0;
        step_btn = 1'b1;
        run_sw = 1'b0;
        #1;
        check("async_rst_cpu_en", cpu_en, 0);
        check("async_rst_state", state, ST_IDLE);
        check("async_rst_count", instr_cnt, 0);
        model_cnt = 0;
        pc_m = 32'h0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        step_btn = 1'b0;
        repeat (4) @(negedge clk);
        check("held_step_no_pulse_count", instr_cnt, 0);
        check("held_step_state", state, ST_IDLE);

        // DIV_COUNT = 1: continuous issue and 16-bit wrap
        @(negedge clk);
        k = cyc + 1;
        run_sw1 = 1'b1;
        enter = k + 2;
        while (cyc < enter + 1) @(negedge clk);
        check("div1_first_pulse", cpu_en1, 1);
        check("div1_first_count", instr_cnt1, 0);
        low = 0;
        for (int i = 1; i < 65536; i++) begin
            @(negedge clk);
            if (!cpu_en1) low++;
        end
        check("div1_gap_cycles", low, 0);
        check("div1_count_ffff", instr_cnt1, 16'hFFFF);
        @(negedge clk);
        check("div1_count_wrap", instr_cnt1, 0);
        check("div1_still_running", cpu_en1, 1);
        run_sw1 = 1'b0;
        repeat (5) @(negedge clk);
        check("div1_stop_state", state1, ST_IDLE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/run_step_controller.md
Name: run_step_controller

Overview:
- Sequences instruction issue for the MIPS datapath through a one-cycle clock-enable, `CpuEn`. The processor core advances one instruction per `CpuEn` pulse.
- Three issue modes:
  - free-running at a prescaled rate,
  - single-step on a button press,
  - automatic halt on a PC breakpoint.
- Sits between the board inputs (switch, button, breakpoint address) and the processor core. `Halted` and `InstrCount` go to the display logic.

Parameters:
- DIV_COUNT, 50000000, `Clk` cycles between issued instructions in RUN mode; legal range 1 to 2^26.
- PC_W, 32, width of `PCValue` and `BreakAddr`.

Ports:
- Clk  input  1  system clock.
- Rst  input  1  asynchronous, active-low reset.
- RunSw  input  1  asynchronous run switch level.
- StepBtn  input  1  asynchronous, pre-debounced step button level.
- BreakEn  input  1  breakpoint enable; synchronous to `Clk`.
- BreakAddr  input  PC_W  breakpoint address.
- PCValue  input  PC_W  address of the next instruction the core will execute.
- CpuEn  output  1  registered; high exactly one cycle per issued instruction.
- State  output  2  current FSM state encoding.
- Halted  output  1  high while State = BREAK.
- InstrCount  output  16  count of issued `CpuEn` pulses; wraps.

Behaviour:
- Reset (Rst = 0, asynchronous), all immediate:
  - State = IDLE (2'b00), CpuEn = 0, InstrCount = 0, prescaler = 0.
  - Synchronizer flops = 0.
  - Edge-detector "previous" registers = 1, so a level held high through reset release produces no edge.
- Input synchronization:
  - `RunSw` and `StepBtn` each pass through a 2-flop synchronizer, then a rising-edge detector.
  - Outputs are `run_s`, `run_rise`, `step_rise`.
  - Edge latency: 2 `Clk` edges from first sampling high.
- FSM state encodings: IDLE = 00, RUN = 01, STEP = 10, BREAK = 11.
- IDLE:
  - `step_rise` → STEP. This has priority over `run_rise`.
  - `run_rise` → RUN, with prescaler cleared to 0.
  - A steady-high `run_s` does not enter RUN; resuming requires a fresh rising edge.
- STEP (one cycle long):
  - CpuEn = 1 on the next cycle.
  - Unconditional transition → IDLE.
- RUN:
  - If `run_s` = 0: → IDLE, no pulse, prescaler cleared. This has priority over everything else.
  - Otherwise the prescaler increments each cycle.
  - At terminal count (DIV_COUNT−1) the prescaler wraps to 0, and:
    - if BreakEn = 1 and PCValue == BreakAddr: → BREAK, no pulse;
    - otherwise CpuEn = 1 on the next cycle.
  - `step_rise` is ignored.
- BREAK:
  - `step_rise` → STEP, issuing exactly one instruction past the breakpoint; then IDLE.
  - Else if `run_s` = 0: → IDLE.
  - CpuEn stays 0.
- DIV_COUNT = 1: terminal count every cycle, so CpuEn is continuously high in RUN, subject to the breakpoint check every cycle.
- InstrCount: increments in the cycle CpuEn is high; 16'hFFFF wraps to 16'h0000.
- Latencies:
  - StepBtn high at sampling edge k → STEP at edge k+2 → CpuEn high in the cycle after edge k+3.
  - First RUN pulse is DIV_COUNT cycles after entering RUN.
- Rst asserted mid-pulse: CpuEn drops immediately; no partial state is retained.

Decomposition:
- Shared package `run_ctrl_pkg`:
  - the four 2-bit state encodings as localparams;
  - the prescaler width function (clog2 of DIV_COUNT).
- One sub-module, `sync_edge_detect`:
  - 2-flop synchronizer plus rising-edge register;
  - resets on `Rst` with synchronizer = 0 and prev = 1;
  - outputs `level` and `rise`;
  - instantiated twice, for `RunSw` and `StepBtn`.

Test Plan:
All scenarios use DIV_COUNT = 4 unless noted.
1. Run: BreakEn = 0, RunSw rises → CpuEn pulses every 4 cycles; after 5 pulses InstrCount = 5. RunSw falls mid-count → no further pulse, State = 00.
2. Step: from IDLE, StepBtn held high for 20 cycles → exactly one CpuEn pulse, 4 edges after first sample; InstrCount = 1. A second press gives InstrCount = 2.
3. Breakpoint: BreakEn = 1, BreakAddr = 0x00000008, PCValue advancing 0→4→8 on each pulse → exactly 2 pulses, then State = 11, Halted = 1, no pulses for 50 cycles.
4. Step past breakpoint: in BREAK, StepBtn press → one pulse, State = 00, Halted = 0. With RunSw still high, no RUN until RunSw toggles low then high.
5. Async reset mid-RUN: Rst = 0 during a CpuEn-high cycle → CpuEn, InstrCount and State go to 0 before the next Clk edge. A StepBtn held high across reset release produces no pulse.
6. Wrap (DIV_COUNT = 1): RUN for 65536 cycles → CpuEn continuously high; InstrCount returns to 0x0000.
